freq_calc: RTL and testbench

Converts each raw measurement word from `measure` into a frequency in Hz. `measure` sits directly upstream and produces the raw word. Each 64-bit result holds a reference-clock count and a signal-clock count taken over one gate. The block computes `sig_cnt * REF_CLK_HZ / ref_cnt` with a registered multiply and a serial restoring divider. It presents the result as a one-cycle valid pulse to the AXI register bank downstream.

---
 rtl/dfm_pkg.sv | 29 ++
 rtl/freq_calc_if.sv | 32 +++
 rtl/div_u64_u32.sv | 63 ++++++
 rtl/freq_calc.sv | 180 ++++++++++++++++++
 tb/tb_freq_calc.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dfm_pkg.sv
//------------------------------------------------------------------------------
// dfm_pkg : types and constants shared by measure / freq_calc
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dfm_pkg;

    localparam int MEAS_W = 64;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic [CNT_W-1:0] ref_cnt;
        logic [CNT_W-1:0] sig_cnt;
    } meas_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
`ifdef FREQ_CALC_ROUND_EN
        ST_RND  = 3'd3,
`endif
        ST_DONE = 3'd4
    } freq_calc_state_t;

endpackage

`default_nettype wire

// File: rtl/freq_calc_if.sv
//------------------------------------------------------------------------------
// freq_calc_if : measurement input / frequency result bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface freq_calc_if #(
    parameter int DROP_CNT_W = 8
);
    import dfm_pkg::*;

    logic                  meas_valid_i;
    logic [MEAS_W-1:0]     meas_data_i;
    logic                  freq_valid_o;
    logic [CNT_W-1:0]      freq_data_o;
    logic                  err_o;
    logic                  busy_o;
    logic [DROP_CNT_W-1:0] drop_cnt_o;

    modport master (
        output meas_valid_i, meas_data_i,
        input  freq_valid_o, freq_data_o, err_o, busy_o, drop_cnt_o
    );

    modport slave (
        input  meas_valid_i, meas_data_i,
        output freq_valid_o, freq_data_o, err_o, busy_o, drop_cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/div_u64_u32.sv
//------------------------------------------------------------------------------
// div_u64_u32 : serial restoring divider, 64-bit / 32-bit, one bit per cycle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_u64_u32 (
    input  wire logic        clk_i,
    input  wire logic        rst_n_i,
    input  wire logic        i_start,
    input  wire logic [63:0] i_dividend,
    input  wire logic [31:0] i_divisor,
    output logic             o_done,
    output logic [63:0]      o_quotient,
    output logic [31:0]      o_remainder
);

    logic [63:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dsr;
    logic [5:0]  r_cnt;
    logic        r_run;

    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic        w_ge;

    // Dividend bits shift out of r_quo as quotient bits shift in.
    assign w_trial = {r_rem, r_quo[63]};
    assign w_diff  = w_trial - {1'b0, r_dsr};
    assign w_ge    = (w_trial >= {1'b0, r_dsr});

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dsr <= i_divisor;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_quo <= {r_quo[62:0], w_ge};
            r_rem <= w_ge ? w_diff[31:0] : w_trial[31:0];
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd63) begin
                r_run <= 1'b0;
            end
        end
    end

    // High in the cycle whose closing edge writes the final quotient bit.
    assign o_done      = r_run && (r_cnt == 6'd63);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

`default_nettype wire

// File: rtl/freq_calc.sv
//------------------------------------------------------------------------------
// freq_calc : raw measure word -> sig_cnt * REF_CLK_HZ / ref_cnt in Hz
// Optional rounding: define FREQ_CALC_ROUND_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module freq_calc
    import dfm_pkg::*;
#(
    parameter int unsigned REF_CLK_HZ = 200_000_000,
    parameter int          DROP_CNT_W = 8
) (
    input  wire logic  clk_i,
    input  wire logic  rst_n_i,
    freq_calc_if.slave bus
);

    localparam logic [CNT_W-1:0] c_REF_HZ = CNT_W'(REF_CLK_HZ);

    freq_calc_state_t r_state;
    freq_calc_state_t w_next_state;

    meas_t                 w_in;
    meas_t                 w_sample;
    meas_t                 r_slot;
    logic                  r_slot_vld;
    logic [CNT_W-1:0]      r_ref_cnt;
    logic [CNT_W-1:0]      r_sig_cnt;
    logic                  r_zero;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  r_freq_valid;
    logic [CNT_W-1:0]      r_freq_data;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_div_start;
    logic                  w_div_done;
    logic                  w_slot_wr;
    logic                  w_drop;
    logic [MEAS_W-1:0]     w_product;
    logic [MEAS_W-1:0]     w_div_quo;
    logic [CNT_W-1:0]      w_div_rem;
    logic [MEAS_W-1:0]     w_final_quo;
    logic [CNT_W-1:0]      w_freq_sat;

    assign w_in      = meas_t'(bus.meas_data_i);
    assign w_sample  = r_slot_vld ? r_slot : w_in;
    assign w_product = MEAS_W'(r_sig_cnt) * MEAS_W'(c_REF_HZ);

    // In IDLE a full slot is drained this cycle, so a new strobe refills it without a drop.
    assign w_slot_wr = bus.meas_valid_i && ((r_state != ST_IDLE) || r_slot_vld);
    assign w_drop    = bus.meas_valid_i && (r_state != ST_IDLE) && r_slot_vld;

    div_u64_u32 u_div (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_start     (w_div_start),
        .i_dividend  (w_product),
        .i_divisor   (r_ref_cnt),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_div_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_slot_vld || bus.meas_valid_i) begin
                    w_accept     = 1'b1;
                    w_next_state = (w_sample.ref_cnt == '0) ? ST_DONE : ST_MUL;
                end
            end
            ST_MUL: begin
                w_div_start  = 1'b1;
                w_next_state = ST_DIV;
            end
            ST_DIV: begin
                if (w_div_done) begin
`ifdef FREQ_CALC_ROUND_EN
                    w_next_state = ST_RND;
`else
                    w_next_state = ST_DONE;
`endif
                end
            end
`ifdef FREQ_CALC_ROUND_EN
            ST_RND: begin
                w_next_state = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

`ifdef FREQ_CALC_ROUND_EN
    logic [MEAS_W-1:0] r_quo_rnd;
    logic              w_round_up;

    assign w_round_up = ({w_div_rem, 1'b0} >= {1'b0, r_ref_cnt});

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_quo_rnd <= '0;
        end else if (r_state == ST_RND) begin
            r_quo_rnd <= (w_round_up && !(&w_div_quo)) ? (w_div_quo + MEAS_W'(1)) : w_div_quo;
        end
    end

    assign w_final_quo = r_zero ? '1 : r_quo_rnd;
`else
    logic w_unused_rem;

    assign w_unused_rem = ^w_div_rem;
    assign w_final_quo  = r_zero ? '1 : w_div_quo;
`endif

    assign w_freq_sat = (w_final_quo[63:32] == '0) ? w_final_quo[31:0] : '1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_slot       <= '0;
            r_slot_vld   <= 1'b0;
            r_ref_cnt    <= '0;
            r_sig_cnt    <= '0;
            r_zero       <= 1'b0;
            r_drop_cnt   <= '0;
            r_freq_valid <= 1'b0;
            r_freq_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_slot_wr) begin
                r_slot     <= w_in;
                r_slot_vld <= 1'b1;
            end else if (w_accept && r_slot_vld) begin
                r_slot_vld <= 1'b0;
            end

            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end

            if (w_accept) begin
                r_ref_cnt <= w_sample.ref_cnt;
                r_sig_cnt <= w_sample.sig_cnt;
                r_zero    <= (w_sample.ref_cnt == '0);
            end

            r_freq_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_freq_data <= w_freq_sat;
                r_err       <= r_zero;
            end
        end
    end

    assign bus.freq_valid_o = r_freq_valid;
    assign bus.freq_data_o  = r_freq_data;
    assign bus.err_o        = r_err;
    assign bus.busy_o       = (r_state != ST_IDLE);
    assign bus.drop_cnt_o   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_freq_calc.sv
//------------------------------------------------------------------------------
// tb_freq_calc : directed scoreboard bench for freq_calc
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_freq_calc;

    localparam longint unsigned REF = 200_000_000;
`ifdef FREQ_CALC_ROUND_EN
    localparam int LAT = 67;
`else
    localparam int LAT = 66;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_exp;

    freq_calc_if #(.DROP_CNT_W(8)) bus ();

    freq_calc #(
        .REF_CLK_HZ (200_000_000),
        .DROP_CNT_W (8)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] rc, input logic [31:0] sc);
        longint unsigned n;
        longint unsigned q;
        longint unsigned r;
        exp_t x;
        if (rc == 32'd0) begin
            x.data = 32'hFFFF_FFFF;
            x.err  = 1'b1;
            return x;
        end
        n = longint'(sc) * REF;
        q = n / longint'(rc);
        r = n % longint'(rc);
`ifdef FREQ_CALC_ROUND_EN
        if (2 * r >= longint'(rc)) q = q + 1;
`endif
        x.data = (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
        x.err  = 1'b0;
        return x;
    endfunction

    // Drives a one-cycle strobe; returns at the negedge just after the acceptance edge.
    task automatic send(input logic [31:0] rc, input logic [31:0] sc, input bit expect_out);
        @(negedge clk);
        bus.meas_valid_i = 1'b1;
        bus.meas_data_i  = {rc, sc};
        if (expect_out) sb.push_back(model(rc, sc));
        @(negedge clk);
        bus.meas_valid_i = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat, input string tag);
        int lat;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.freq_valid_o) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        assert (lat === exp_lat) else begin
            n_fail++;
            $error("FAIL %s_latency: observed %0d required %0d", tag, lat, exp_lat);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        assert (bus.freq_valid_o === 1'b0) else begin n_fail++; $error("FAIL %s_valid: observed %b required 0", tag, bus.freq_valid_o); end
        n_cmp++;
        assert (bus.freq_data_o === 32'd0) else begin n_fail++; $error("FAIL %s_data: observed %h required 0", tag, bus.freq_data_o); end
        n_cmp++;
        assert (bus.err_o === 1'b0) else begin n_fail++; $error("FAIL %s_err: observed %b required 0", tag, bus.err_o); end
        n_cmp++;
        assert (bus.busy_o === 1'b0) else begin n_fail++; $error("FAIL %s_busy: observed %b required 0", tag, bus.busy_o); end
        n_cmp++;
        assert (bus.drop_cnt_o === 8'd0) else begin n_fail++; $error("FAIL %s_drop: observed %0d required 0", tag, bus.drop_cnt_o); end
    endtask

    always @(negedge clk) begin
        if (bus.freq_valid_o) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_result: observed data %h with empty queue, required no result", bus.freq_data_o);
            end
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                n_cmp++;
                assert (bus.freq_data_o === mon_exp.data) else begin
                    n_fail++;
                    $error("FAIL result_data: observed %0d required %0d", bus.freq_data_o, mon_exp.data);
                end
                n_cmp++;
                assert (bus.err_o === mon_exp.err) else begin
                    n_fail++;
                    $error("FAIL result_err: observed %b required %b", bus.err_o, mon_exp.err);
                end
            end
        end
    end

    initial begin
        int guard;
        logic [31:0] rc;
        logic [31:0] sc;

        rst_n            = 1'b0;
        bus.meas_valid_i = 1'b0;
        bus.meas_data_i  = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(32'd2000, 32'd20, 1'b1);
        n_cmp++;
        assert (bus.busy_o === 1'b1) else begin n_fail++; $error("FAIL busy_rise: observed %b required 1", bus.busy_o); end
        wait_result(LAT, "basic");
        n_cmp++;
        assert (bus.busy_o === 1'b0) else begin n_fail++; $error("FAIL busy_fall: observed %b required 0", bus.busy_o); end
        repeat (3) @(negedge clk);
        n_cmp++;
        assert (bus.freq_data_o === 32'd2_000_000) else begin n_fail++; $error("FAIL data_hold: observed %0d required 2000000", bus.freq_data_o); end

        send(32'd3, 32'd1, 1'b1);
        wait_result(LAT, "round");

        send(32'd0, 32'd5, 1'b1);
        wait_result(1, "zero_ref");

        send(32'd1, 32'hFFFF_FFFF, 1'b1);
        wait_result(LAT, "saturate");

        // A accepted, B parked, C overwrites B.
        send(32'd1000, 32'd3, 1'b1);
        repeat (8) @(negedge clk);
        send(32'd500, 32'd9, 1'b0);
        repeat (8) @(negedge clk);
        send(32'd250, 32'd11, 1'b1);
        guard = 0;
        while (sb.size() > 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        assert (sb.size() === 0) else begin n_fail++; $error("FAIL drop_results: observed %0d pending required 0", sb.size()); end
        n_cmp++;
        assert (bus.drop_cnt_o === 8'd1) else begin n_fail++; $error("FAIL drop_cnt: observed %0d required 1", bus.drop_cnt_o); end
        repeat (3) @(negedge clk);

        send(32'd5000, 32'd1000, 1'b0);
        repeat (32) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(32'd1000, 32'd7, 1'b1);
        wait_result(LAT, "post_reset");

        for (int i = 0; i < 3; i++) begin
            rc = 32'($urandom_range(1, 100000));
            sc = $urandom;
            send(rc, sc, 1'b1);
            wait_result(LAT, "random");
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        assert (sb.size() === 0) else begin n_fail++; $error("FAIL final_queue: observed %0d pending required 0", sb.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
